// File: rtl/dig_pkg.sv
// Shared types and default timeout constants for the SPI/UART ownership arbiter.
package dig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int unsigned SPI_TO_DEF  = 2048;
    localparam int unsigned UART_TO_DEF = 65536;

endpackage

// File: rtl/busy_timer.sv
// Busy flag with a saturating watchdog counter for one shared peripheral.
import dig_pkg::*;

module busy_timer #(
    parameter int unsigned TO = SPI_TO_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic done,
    output logic busy,
    output logic timeout_c
);

    localparam int unsigned CW   = $clog2(TO);
    localparam logic [CW-1:0] TERM = CW'(TO - 1);

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          term;

    // A completion on the terminal cycle takes priority over the timeout
    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        term      = busy_q && (cnt_q == TERM);
        timeout_c = term && !done;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q) begin
            if (done || term) begin
                busy_d = 1'b0;
            end
            if (cnt_q != TERM) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/spi_uart_arbiter.sv
// Shares the SPI master and UART response path between the command unit (0)
// and the dump sequencer (1) via a round-robin ownership handshake.
import dig_pkg::*;

module spi_uart_arbiter #(
    parameter int unsigned SPI_TO  = SPI_TO_DEF,
    parameter int unsigned UART_TO = UART_TO_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic        wrt_SPI0,
    input  logic        wrt_SPI1,
    input  logic [15:0] SPI_data0,
    input  logic [15:0] SPI_data1,
    input  logic [2:0]  ss0,
    input  logic [2:0]  ss1,
    input  logic        send_resp0,
    input  logic        send_resp1,
    input  logic [7:0]  resp_data0,
    input  logic [7:0]  resp_data1,
    output logic        SPI_done0,
    output logic        SPI_done1,
    output logic        resp_sent0,
    output logic        resp_sent1,
    output logic        wrt_SPI,
    output logic [15:0] SPI_data,
    output logic [2:0]  ss,
    input  logic        SPI_done,
    output logic        send_resp,
    output logic [7:0]  resp_data,
    input  logic        resp_sent,
    output logic        spi_busy,
    output logic        uart_busy,
    output logic        proto_err,
    output logic        to_err
);

    arb_state_t  state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        wrt_spi_q, wrt_spi_d, send_resp_q, send_resp_d;
    logic [15:0] spi_data_q, spi_data_d;
    logic [2:0]  ss_q, ss_d;
    logic [7:0]  resp_data_q, resp_data_d;
    logic        proto_err_q, proto_err_d, to_err_q, to_err_d;

    logic acc_spi0, acc_spi1, acc_uart0, acc_uart1;
    logic spi_start, uart_start, spi_to_c, uart_to_c;

    busy_timer #(.TO(SPI_TO)) u_spi_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (spi_start),
        .done      (SPI_done),
        .busy      (spi_busy),
        .timeout_c (spi_to_c)
    );

    busy_timer #(.TO(UART_TO)) u_uart_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (uart_start),
        .done      (resp_sent),
        .busy      (uart_busy),
        .timeout_c (uart_to_c)
    );

    always_comb begin
        acc_spi0    = wrt_SPI0 && gnt0_q && !spi_busy;
        acc_spi1    = wrt_SPI1 && gnt1_q && !spi_busy;
        acc_uart0   = send_resp0 && gnt0_q && !uart_busy;
        acc_uart1   = send_resp1 && gnt1_q && !uart_busy;
        spi_start   = acc_spi0 || acc_spi1;
        uart_start  = acc_uart0 || acc_uart1;

        state_d      = state_q;
        last_owner_d = last_owner_q;
        spi_data_d   = spi_data_q;
        ss_d         = ss_q;
        resp_data_d  = resp_data_q;
        wrt_spi_d    = spi_start;
        send_resp_d  = uart_start;
        proto_err_d  = (wrt_SPI0 && !acc_spi0) || (wrt_SPI1 && !acc_spi1) ||
                       (send_resp0 && !acc_uart0) || (send_resp1 && !acc_uart1);
        to_err_d     = spi_to_c || uart_to_c;

        // Release waits for both resources and any transfer starting this cycle
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0 && !spi_busy && !uart_busy && !spi_start && !uart_start) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end
            end
            OWN1: begin
                if (!req1 && !spi_busy && !uart_busy && !spi_start && !uart_start) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (acc_spi0) begin
            spi_data_d = SPI_data0;
            ss_d       = ss0;
        end else if (acc_spi1) begin
            spi_data_d = SPI_data1;
            ss_d       = ss1;
        end
        if (acc_uart0) begin
            resp_data_d = resp_data0;
        end else if (acc_uart1) begin
            resp_data_d = resp_data1;
        end

        gnt0_d = (state_d == OWN0);
        gnt1_d = (state_d == OWN1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            wrt_spi_q    <= 1'b0;
            send_resp_q  <= 1'b0;
            spi_data_q   <= '0;
            ss_q         <= '0;
            resp_data_q  <= '0;
            proto_err_q  <= 1'b0;
            to_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            wrt_spi_q    <= wrt_spi_d;
            send_resp_q  <= send_resp_d;
            spi_data_q   <= spi_data_d;
            ss_q         <= ss_d;
            resp_data_q  <= resp_data_d;
            proto_err_q  <= proto_err_d;
            to_err_q     <= to_err_d;
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign wrt_SPI    = wrt_spi_q;
    assign SPI_data   = spi_data_q;
    assign ss         = ss_q;
    assign send_resp  = send_resp_q;
    assign resp_data  = resp_data_q;
    assign proto_err  = proto_err_q;
    assign to_err     = to_err_q;

    // Completions are routed combinationally to the current owner only
    assign SPI_done0  = SPI_done  && spi_busy  && (state_q == OWN0);
    assign SPI_done1  = SPI_done  && spi_busy  && (state_q == OWN1);
    assign resp_sent0 = resp_sent && uart_busy && (state_q == OWN0);
    assign resp_sent1 = resp_sent && uart_busy && (state_q == OWN1);

endmodule

// File: tb/tb_spi_uart_arbiter.sv
// Self-checking bench for spi_uart_arbiter: vector table, scoreboards and
// hand-written multi-cycle sequences.
module tb_spi_uart_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, gnt0, gnt1;
    logic        wrt_SPI0, wrt_SPI1, send_resp0, send_resp1;
    logic [15:0] SPI_data0, SPI_data1, SPI_data;
    logic [2:0]  ss0, ss1, ss;
    logic [7:0]  resp_data0, resp_data1, resp_data;
    logic        SPI_done0, SPI_done1, resp_sent0, resp_sent1;
    logic        wrt_SPI, SPI_done, send_resp, resp_sent;
    logic        spi_busy, uart_busy, proto_err, to_err;

    int n_vec = 0;
    int n_err = 0;

    logic [18:0] spi_q[$];
    logic [7:0]  uart_q[$];

    typedef struct {
        logic        w0, w1, s0, s1;
        logic [15:0] sd;
        logic [7:0]  rd;
        logic        ew, es, ep;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    spi_uart_arbiter #(.SPI_TO(16), .UART_TO(32)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1),
        .wrt_SPI0(wrt_SPI0), .wrt_SPI1(wrt_SPI1),
        .SPI_data0(SPI_data0), .SPI_data1(SPI_data1),
        .ss0(ss0), .ss1(ss1),
        .send_resp0(send_resp0), .send_resp1(send_resp1),
        .resp_data0(resp_data0), .resp_data1(resp_data1),
        .SPI_done0(SPI_done0), .SPI_done1(SPI_done1),
        .resp_sent0(resp_sent0), .resp_sent1(resp_sent1),
        .wrt_SPI(wrt_SPI), .SPI_data(SPI_data), .ss(ss), .SPI_done(SPI_done),
        .send_resp(send_resp), .resp_data(resp_data), .resp_sent(resp_sent),
        .spi_busy(spi_busy), .uart_busy(uart_busy),
        .proto_err(proto_err), .to_err(to_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: every forwarded peripheral pulse must match the next queued capture
    always @(negedge clk) begin
        if (rst_n && wrt_SPI) begin
            if (spi_q.size() == 0) chk("spi_unexpected", 32'({SPI_data, ss}), 32'h7ffff);
            else chk("spi_sb", 32'({SPI_data, ss}), 32'(spi_q.pop_front()));
        end
        if (rst_n && send_resp) begin
            if (uart_q.size() == 0) chk("uart_unexpected", 32'(resp_data), 32'h1ff);
            else chk("uart_sb", 32'(resp_data), 32'(uart_q.pop_front()));
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h2345, 8'h22, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h3456, 8'h33, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h4567, 8'h44, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h5678, 8'h55, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h6789, 8'h66, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h789A, 8'h77, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h89AB, 8'h88, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        {req0, req1, wrt_SPI0, wrt_SPI1, send_resp0, send_resp1, SPI_done, resp_sent} = '0;
        SPI_data0 = '0; SPI_data1 = '0; ss0 = '0; ss1 = '0;
        resp_data0 = '0; resp_data1 = '0;
        repeat (3) cyc();
        chk("rst_outputs", 32'({gnt0, gnt1, wrt_SPI, send_resp, spi_busy, uart_busy,
                                proto_err, to_err, SPI_data, ss, resp_data}), 0);
        rst_n = 1'b1;
        cyc();

        // Grant latency and a basic SPI transfer
        req0 = 1'b1;
        #1 chk("gnt0_latency_pre", 32'(gnt0), 0);
        cyc();
        chk("gnt0_granted", 32'({gnt0, gnt1}), 32'b10);
        wrt_SPI0 = 1'b1; SPI_data0 = 16'hA5C3; ss0 = 3'b001;
        spi_q.push_back({16'hA5C3, 3'b001});
        cyc();
        wrt_SPI0 = 1'b0;
        chk("wrt_spi_pulse", 32'({wrt_SPI, spi_busy}), 32'b11);
        cyc();
        chk("wrt_spi_one_cycle", 32'(wrt_SPI), 0);
        chk("spi_data_hold", 32'({SPI_data, ss}), 32'({16'hA5C3, 3'b001}));
        repeat (8) cyc();
        SPI_done = 1'b1;
        #1 chk("spi_done_routed", 32'({SPI_done0, SPI_done1}), 32'b10);
        cyc();
        SPI_done = 1'b0;
        chk("spi_busy_cleared", 32'({spi_busy, to_err}), 0);

        // Acceptance/rejection table while requester 0 owns idle resources
        foreach (vecs[i]) begin
            {wrt_SPI0, wrt_SPI1, send_resp0, send_resp1} = {vecs[i].w0, vecs[i].w1, vecs[i].s0, vecs[i].s1};
            SPI_data0 = vecs[i].sd; SPI_data1 = ~vecs[i].sd; ss0 = 3'(i); ss1 = 3'(7 - i);
            resp_data0 = vecs[i].rd; resp_data1 = ~vecs[i].rd;
            if (vecs[i].ew) spi_q.push_back({vecs[i].sd, 3'(i)});
            if (vecs[i].es) uart_q.push_back(vecs[i].rd);
            cyc();
            {wrt_SPI0, wrt_SPI1, send_resp0, send_resp1} = '0;
            chk($sformatf("vec%0d_out", i), 32'({wrt_SPI, send_resp, proto_err, spi_busy, uart_busy}),
                32'({vecs[i].ew, vecs[i].es, vecs[i].ep, vecs[i].ew, vecs[i].es}));
            SPI_done = vecs[i].ew; resp_sent = vecs[i].es;
            #1 chk($sformatf("vec%0d_done", i), 32'({SPI_done0, resp_sent0, SPI_done1, resp_sent1}),
                   32'({vecs[i].ew, vecs[i].es, 2'b00}));
            cyc();
            SPI_done = 1'b0; resp_sent = 1'b0;
            chk($sformatf("vec%0d_idle", i), 32'({spi_busy, uart_busy}), 0);
        end

        // Second start while busy is dropped; completion plus new start is rejected too
        wrt_SPI0 = 1'b1; SPI_data0 = 16'h1111; ss0 = 3'b010;
        spi_q.push_back({16'h1111, 3'b010});
        cyc();
        SPI_data0 = 16'h2222; ss0 = 3'b011;
        cyc();
        wrt_SPI0 = 1'b0;
        chk("busy_reject", 32'({proto_err, wrt_SPI, SPI_data}), 32'({1'b1, 1'b0, 16'h1111}));
        wrt_SPI0 = 1'b1; SPI_data0 = 16'h3333; SPI_done = 1'b1;
        cyc();
        SPI_done = 1'b0; SPI_data0 = 16'h4444; ss0 = 3'b100;
        spi_q.push_back({16'h4444, 3'b100});
        chk("done_accept_collide", 32'({proto_err, wrt_SPI, spi_busy, SPI_data}),
            32'({3'b100, 16'h1111}));
        cyc();
        wrt_SPI0 = 1'b0;
        chk("retry_accept", 32'({wrt_SPI, spi_busy, proto_err}), 32'b110);
        SPI_done = 1'b1;
        cyc();
        SPI_done = 1'b0;

        // SPI timeout: to_err lands exactly 16 cycles after the wrt_SPI pulse
        wrt_SPI0 = 1'b1; SPI_data0 = 16'hBEEF; ss0 = 3'b101;
        spi_q.push_back({16'hBEEF, 3'b101});
        cyc();
        wrt_SPI0 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk($sformatf("spi_to_k%0d", k), 32'({to_err, spi_busy}), (k == 16) ? 32'b10 : 32'b01);
        end
        cyc();
        chk("to_err_one_cycle", 32'(to_err), 0);

        // Completion on the terminal cycle wins over the timeout
        wrt_SPI0 = 1'b1; SPI_data0 = 16'hCAFE;
        spi_q.push_back({16'hCAFE, 3'b101});
        cyc();
        wrt_SPI0 = 1'b0;
        repeat (15) cyc();
        SPI_done = 1'b1;
        #1 chk("term_done_routed", 32'(SPI_done0), 1);
        cyc();
        SPI_done = 1'b0;
        chk("term_done_no_to", 32'({to_err, spi_busy}), 0);
        cyc();
        chk("term_done_no_to_late", 32'(to_err), 0);

        // UART timeout
        send_resp0 = 1'b1; resp_data0 = 8'hE1;
        uart_q.push_back(8'hE1);
        cyc();
        send_resp0 = 1'b0;
        repeat (31) cyc();
        chk("uart_to_pre", 32'({to_err, uart_busy}), 32'b01);
        cyc();
        chk("uart_to", 32'({to_err, uart_busy}), 32'b10);

        // Release request while UART busy: grant holds until completion
        send_resp0 = 1'b1; resp_data0 = 8'h5A;
        uart_q.push_back(8'h5A);
        cyc();
        send_resp0 = 1'b0;
        repeat (2) cyc();
        req0 = 1'b0; req1 = 1'b1;
        repeat (4) cyc();
        chk("hold_gnt", 32'({gnt0, gnt1, uart_busy}), 32'b101);
        resp_sent = 1'b1;
        #1 chk("hold_resp_sent0", 32'({resp_sent0, resp_sent1}), 32'b10);
        cyc();
        resp_sent = 1'b0;
        chk("hold_still_gnt", 32'({gnt0, uart_busy}), 32'b10);
        cyc();
        chk("hold_idle_gap", 32'({gnt0, gnt1}), 0);
        cyc();
        chk("hold_gnt1", 32'({gnt0, gnt1}), 32'b01);

        // Reset in the middle of a UART transaction owned by requester 1
        send_resp1 = 1'b1; resp_data1 = 8'hC7;
        uart_q.push_back(8'hC7);
        cyc();
        send_resp1 = 1'b0;
        chk("own1_uart_busy", 32'(uart_busy), 1);
        cyc();
        rst_n = 1'b0; resp_sent = 1'b1;
        #1 chk("mid_rst_outputs", 32'({gnt0, gnt1, wrt_SPI, send_resp, spi_busy, uart_busy, proto_err,
                                       to_err, resp_sent0, resp_sent1, SPI_data, ss, resp_data}), 0);
        resp_sent = 1'b0; req0 = 1'b1; req1 = 1'b1;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_tie", 32'({gnt0, gnt1}), 32'b10);

        // Round-robin alternation with both requesters contending
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("rr%0d_owner", r), 32'({gnt0, gnt1}), (r % 2 == 0) ? 32'b10 : 32'b01);
            if (r % 2 == 0) begin
                wrt_SPI0 = 1'b1; SPI_data0 = 16'(r + 16'h100); ss0 = 3'b110;
                spi_q.push_back({16'(r + 16'h100), 3'b110});
            end else begin
                wrt_SPI1 = 1'b1; SPI_data1 = 16'(r + 16'h200); ss1 = 3'b111;
                spi_q.push_back({16'(r + 16'h200), 3'b111});
            end
            cyc();
            wrt_SPI0 = 1'b0; wrt_SPI1 = 1'b0;
            if (r % 2 == 0) req0 = 1'b0; else req1 = 1'b0;
            repeat (3) cyc();
            SPI_done = 1'b1;
            #1 chk($sformatf("rr%0d_done", r), 32'({SPI_done0, SPI_done1}),
                   (r % 2 == 0) ? 32'b10 : 32'b01);
            cyc();
            SPI_done = 1'b0;
            cyc();
            chk($sformatf("rr%0d_gap", r), 32'({gnt0, gnt1}), 0);
            req0 = 1'b1; req1 = 1'b1;
            cyc();
        end

        cyc();
        chk("sb_drained", 32'(spi_q.size() + uart_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
